// File: rtl/pad_input_conditioner_if.sv
// rtl/pad_input_conditioner_if.sv - raw pad inputs and conditioned per-channel outputs
interface pad_input_conditioner_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] n_pad_i;
   logic [CHANNELS-1:0] bypass_i;
   logic [CHANNELS-1:0] level_o;
   logic [CHANNELS-1:0] press_o;
   logic [CHANNELS-1:0] release_o;
   logic [CHANNELS-1:0] long_press_o;

   modport master (
      output n_pad_i,
      output bypass_i,
      input  level_o,
      input  press_o,
      input  release_o,
      input  long_press_o
   );

   modport slave (
      input  n_pad_i,
      input  bypass_i,
      output level_o,
      output press_o,
      output release_o,
      output long_press_o
   );
endinterface

// File: rtl/pad_input_conditioner.sv
// rtl/pad_input_conditioner.sv - synchronise, debounce and edge-detect active-low pad inputs
module pad_input_conditioner #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 64,
   parameter int LONG_CYCLES     = 32768
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   pad_input_conditioner_if.slave pad
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [CHANNELS-1:0] level_vec;
   logic [CHANNELS-1:0] press_vec;
   logic [CHANNELS-1:0] release_vec;
   logic [CHANNELS-1:0] long_vec;

   assign pad.level_o      = level_vec;
   assign pad.press_o      = press_vec;
   assign pad.release_o    = release_vec;
   assign pad.long_press_o = long_vec;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      // Stage 0 samples the pad; the last stage is the metastability-safe copy.
      logic [SYNC_STAGES-1:0] sync_q;
      logic [DW-1:0]          db_cnt_q;
      logic [DW-1:0]          db_cnt_d;
      logic                   level_q;
      logic                   level_d;
      logic                   press_q;
      logic                   release_q;
      logic                   raw;

      assign raw = ~sync_q[SYNC_STAGES-1];

      // Next debounced level: follow raw only after it has differed for the full window.
      always_comb begin
         level_d  = level_q;
         db_cnt_d = '0;
         if (pad.bypass_i[c]) begin
            level_d = raw;
         end else if (raw != level_q) begin
            if (db_cnt_q == DB_LAST) begin
               level_d = raw;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
      end

      // Synchroniser, debounce state and registered edge pulses.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            sync_q    <= '1;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pad.n_pad_i[c]};
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
         end
      end

      assign level_vec[c]   = level_q;
      assign press_vec[c]   = press_q;
      assign release_vec[c] = release_q;

      if (LONG_CYCLES > 0) begin : g_long
         localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
         localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);

         logic [HW-1:0] hold_q;
         logic [HW-1:0] hold_d;
         logic          long_q;

         // Hold time counts cycles with Level high (press cycle included), saturating.
         always_comb begin
            hold_d = hold_q;
            if (!level_d) begin
               hold_d = '0;
            end else if (hold_q != LONG_MAX) begin
               hold_d = hold_q + 1'b1;
            end
         end

         // Single long-press pulse on the step into saturation.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               hold_q <= '0;
               long_q <= 1'b0;
            end else begin
               hold_q <= hold_d;
               long_q <= level_d && (hold_q == LONG_LAST);
            end
         end

         assign long_vec[c] = long_q;
      end else begin : g_no_long
         assign long_vec[c] = 1'b0;
      end
   end

endmodule

// File: doc/pad_input_conditioner.md
# pad_input_conditioner

Parametrised conditioning stage for the chip's active-low pad inputs: fork and crank sensors, trip and mode buttons. It sits between the input pad cells and the core. Each channel is synchronised, debounced and edge-detected. The core receives clean active-high levels plus one-cycle press, release and long-press pulses, instead of raw asynchronous pad signals. Channel count and all timing windows are generics, so the same block serves any number of sensor or button inputs.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- SYNC_STAGES, 2, synchroniser flop depth (≥2)
- DEBOUNCE_CYCLES, 64, consecutive cycles a new sampled value must persist before Level follows it (≥1)
- LONG_CYCLES, 32768, cycles Level must stay high before LongPress fires; 0 disables LongPress (tied 0)

- Clock  in  1  single system clock; all flops on its rising edge
- Reset  in  1  synchronous, active-high reset
- nPadIn  in  CHANNELS  raw active-low inputs from pad cells; asynchronous to Clock
- Bypass  in  CHANNELS  per-channel debounce bypass; sampled synchronously, 1 = Level follows synchroniser output directly
- Level  out  CHANNELS  debounced active-high state (1 = pad held low)
- Press  out  CHANNELS  one-cycle pulse when Level rises
- Release  out  CHANNELS  one-cycle pulse when Level falls
- LongPress  out  CHANNELS  one-cycle pulse, at most once per hold, when Level has been high for LONG_CYCLES cycles

## Operation
- Channels are fully independent. Any combination of channels may change, press or release in the same cycle.
- **Synchroniser:** SYNC_STAGES-deep chain per channel.
  - Chain reset value is 1 (pad inactive).
  - raw = inverted last stage.
- **Debounce counter:**
  - Per channel; width $clog2(DEBOUNCE_CYCLES+1).
  - raw == Level: counter clears to 0.
  - raw != Level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - raw != Level and counter == DEBOUNCE_CYCLES-1: Level ← raw, counter ← 0.
  - Any single-cycle return of raw to Level restarts the count from 0.
- **Bypass = 1:**
  - Level ← raw every cycle.
  - Debounce counter held at 0.
  - Toggling Bypass mid-count discards the partial count.
- **Edge pulses:**
  - Press and Release are registered. Each is asserted on the same edge Level changes and lasts exactly one cycle.
  - Press and Release are never both high on one channel.
- **Hold counter (LongPress):**
  - Per channel; width $clog2(LONG_CYCLES+1).
  - Cleared while Level = 0.
  - Increments each cycle Level = 1, saturating at LONG_CYCLES.
  - LongPress pulses on the edge the counter transitions LONG_CYCLES-1 → LONG_CYCLES.
  - No re-fire until Level falls and rises again.
  - The Press cycle counts as the first high cycle.
- **Reset:**
  - Every output is 0: Level, Press, Release, LongPress.
  - All counters are 0 and synchroniser stages are 1.
  - Reset during a hold produces no Release pulse.
  - After Reset deasserts, a pad still held low re-qualifies through the full latency and produces a fresh Press.

## Timing
- **Latency, Bypass = 0:** Level and Press assert on the (SYNC_STAGES + DEBOUNCE_CYCLES)th rising edge, counting as edge 1 the first edge that samples nPadIn low. Release follows the same rule on the way up.
- **Latency, Bypass = 1:** SYNC_STAGES + 1 edges.
- **LongPress:** asserts LONG_CYCLES−1 edges after Press.
- **Glitch rejection (Bypass = 0):** a pad pulse shorter than DEBOUNCE_CYCLES sampled cycles never changes Level.
- **Reset precedence:** Reset asserted on an edge overrides every other update on that edge.

## Test plan
Parameters for all scenarios: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=8.

1. Clean press on ch0: drive nPadIn[0] low and hold it. Expect Level[0] and Press[0] on edge 6, Press[0] low on edge 7, LongPress[0] single pulse on edge 13. Then release: expect Release[0] on the 6th edge after the release is first sampled, with Level[0]=0.
2. Bounce on ch1: apply low 3 cycles, high 1, low 3, high 1, then hold low. Expect no Press during the bounce. Expect Press[1] 6 edges after the final sustained low is first sampled.
3. Bypass on ch2: set Bypass[2]=1 and apply a 1-cycle low pulse. Expect Level[2] high for exactly 1 cycle, with Press[2] and Release[2] on consecutive cycles.
4. Simultaneous edges: hold ch0 low while releasing ch3 and pressing ch1 and ch2 on the same edge. Expect independent correct pulses, including Press[1]=Press[2]=1 in the same cycle, with no interaction.
5. Reset mid-hold: after ch0 LongPress, assert Reset for 1 cycle with the pad still low. Expect all outputs 0 and no Release[0]. Expect a new Press[0] on edge 6 after Reset deasserts.
6. LONG_CYCLES=0 build: hold ch0 for 100 cycles. Expect LongPress ≡ 0, with Press and Release behaviour unchanged.
